// File: rtl/contador_crescente_sinc.sv
// Synchronous up-counter with programmable modulus, range-checked parallel load,
// wrap/load-error pulses and a saturating wrap count; all state moves on the falling clk edge.
module contador_crescente_sinc #(
   parameter int WIDTH   = 6,
   parameter int MODULUS = 64,
   parameter int WRAPW   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err,
   output logic [WRAPW-1:0] wraps
);

   localparam logic [WIDTH-1:0] W_MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_load_err;
   logic [WRAPW-1:0] r_wraps;

   logic             w_at_max;
   logic             w_tc;
   logic             w_load_ok;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_tog;

   assign w_at_max  = (r_q == W_MAX);
   assign w_tc      = en & w_at_max;
   assign w_load_ok = ({1'b0, d} < MOD_EXT);

   // Stage i toggles when all lower stages are 1; at the terminal count every set
   // stage toggles so the whole word returns to 0 in a single edge.
   always_comb begin
      w_carry    = '0;
      w_carry[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_carry[i] = w_carry[i-1] & r_q[i-1];
      end
      w_tog = '0;
      if (en) begin
         w_tog = w_at_max ? r_q : w_carry;
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
         r_wraps    <= '0;
      end else if (load) begin
         r_q        <= w_load_ok ? d : '0;
         r_load_err <= ~w_load_ok;
         r_wrap     <= 1'b0;
         r_wraps    <= '0;
      end else begin
         r_q        <= r_q ^ w_tog;
         r_load_err <= 1'b0;
         r_wrap     <= w_tc;
         if (w_tc && (r_wraps != '1)) begin
            r_wraps <= r_wraps + 1'b1;
         end
      end
   end

   assign q        = r_q;
   assign tc       = w_tc;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;
   assign wraps    = r_wraps;

endmodule
